// File: rtl/alu_seq.sv
// alu_seq: execute-stage sequencer in front of an 8-bit combinational ALU.
// Accepts one instruction, registers the ALU operands, captures the result one
// cycle later, writes it back to A or X, and holds it until downstream takes it.
module alu_seq #(
  parameter logic [7:0] RESET_A   = 8'd0,
  parameter logic [7:0] RESET_X   = 8'd0,
  parameter bit         DIV_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_insn,
  output logic [7:0]  alu_i1,
  output logic [7:0]  alu_i2,
  output logic [3:0]  alu_op,
  input  logic [7:0]  alu_o,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_dst,
  output logic        out_err,
  output logic [7:0]  a_reg,
  output logic [7:0]  x_reg,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_n;

  // Instruction field decode
  logic [3:0] op;
  logic       src, dst;
  logic [1:0] rsv;
  logic [7:0] imm, opnd2;
  logic       trap;
  logic       trap_q, dst_q;

  assign op    = in_insn[15:12];
  assign src   = in_insn[11];
  assign dst   = in_insn[10];
  assign rsv   = in_insn[9:8];
  assign imm   = in_insn[7:0];
  assign opnd2 = src ? x_reg : imm;
  // Illegal opcodes are exactly those with op[3] set (8..15).
  assign trap  = op[3] | (|rsv) | (DIV_CHECK && (op == 4'd4) && (opnd2 == 8'd0));

  // Accept only from IDLE; deliberately independent of in_valid.
  assign in_ready = (state == IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state: IDLE -> EXEC -> RESP -> IDLE
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = EXEC;
      EXEC:    state_n = RESP;
      RESP:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: operand capture, writeback, response register, retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= RESET_A;
      x_reg     <= RESET_X;
      retired   <= 16'd0;
      alu_i1    <= 8'd0;
      alu_i2    <= 8'd0;
      alu_op    <= 4'd0;
      trap_q    <= 1'b0;
      dst_q     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      out_dst   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          alu_op <= op;
          alu_i1 <= dst ? x_reg : a_reg;
          alu_i2 <= opnd2;
          trap_q <= trap;
          dst_q  <= dst;
        end
        EXEC: begin
          out_valid <= 1'b1;
          out_dst   <= dst_q;
          out_err   <= trap_q;
          if (trap_q) begin
            out_data <= 8'd0;
          end else begin
            out_data <= alu_o;
            if (dst_q) x_reg <= alu_o;
            else       a_reg <= alu_o;
            if (retired != 16'hFFFF) retired <= retired + 16'd1;
          end
        end
        RESP: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed plus randomized checks of alu_seq against a
// transaction-level model of A, X and the retire count.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_insn;
  logic [7:0]  alu_i1, alu_i2, alu_o;
  logic [3:0]  alu_op;
  logic        out_valid, out_ready, out_dst, out_err;
  logic [7:0]  out_data, a_reg, x_reg;
  logic [15:0] retired;

  int total = 0;
  int bad   = 0;

  // Reference architectural state
  logic [7:0]  ra, rx;
  logic [15:0] rret;

  alu_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
    .alu_i1(alu_i1), .alu_i2(alu_i2), .alu_op(alu_op), .alu_o(alu_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_dst(out_dst), .out_err(out_err),
    .a_reg(a_reg), .x_reg(x_reg), .retired(retired)
  );

  always #5 clk = ~clk;

  // ALU semantics in plain integer arithmetic, truncated to 8 bits
  function automatic logic [7:0] alu_ref(input int op, input int a, input int b);
    int r;
    case (op)
      0: r = b;
      1: r = a + b;
      2: r = a - b;
      3: r = a * b;
      4: r = (b == 0) ? 255 : a / b;
      5: r = a & b;
      6: r = a | b;
      7: r = ~a;
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  // Environment ALU driven from the DUT's registered operands
  always_comb alu_o = alu_ref(int'(alu_op), int'(alu_i1), int'(alu_i2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_insn = 16'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    ra = 8'd0; rx = 8'd0; rret = 16'd0;
  endtask

  // Issue one instruction, check latency/response/writeback, hold the
  // response for 'hold' cycles while offering a competing instruction.
  task automatic run_insn(input logic [15:0] insn, input int hold);
    int op;
    logic [7:0] o1, o2, res, d0, a0, x0;
    logic trap;
    op   = int'(insn[15:12]);
    o1   = insn[10] ? rx : ra;
    o2   = insn[11] ? rx : insn[7:0];
    trap = (op > 7) || (insn[9:8] != 2'b00) || (op == 4 && o2 == 8'd0);
    res  = alu_ref(op, int'(o1), int'(o2));

    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    in_valid = 1'b1; in_insn = insn;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("exec_out_valid", out_valid, 0);
    chk("exec_in_ready", in_ready, 0);
    @(posedge clk); #1;
    if (!trap) begin
      if (insn[10]) rx = res; else ra = res;
      if (rret != 16'hFFFF) rret = rret + 16'd1;
    end
    chk("resp_valid", out_valid, 1);
    chk("resp_err", out_err, trap);
    chk("resp_data", out_data, trap ? 8'd0 : res);
    chk("resp_dst", out_dst, insn[10]);
    chk("a_reg", a_reg, ra);
    chk("x_reg", x_reg, rx);
    chk("retired", retired, rret);
    d0 = out_data; a0 = a_reg; x0 = x_reg;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_insn = 16'h0055;
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, d0);
      chk("hold_dst", out_dst, insn[10]);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_a", a_reg, a0);
      chk("hold_x", x_reg, x0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_valid", out_valid, 0);
    chk("drain_in_ready", in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_insn = 16'h0;
    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_a", a_reg, 0);
    chk("rst_x", x_reg, 0);
    chk("rst_retired", retired, 0);
    chk("rst_alu", {alu_i1, alu_i2, alu_op}, 0);
    chk("rst_out", {out_data, out_dst, out_err}, 0);

    // mov/add with wrap
    run_insn(16'h0005, 0);
    run_insn(16'h10FE, 0);
    chk("add_wrap_a", a_reg, 8'h03);
    chk("add_retired", retired, 2);

    // mul truncation with X operand
    run_insn(16'h0020, 0);
    run_insn(16'h0410, 0);
    run_insn(16'h3800, 0);
    chk("mul_a", a_reg, 8'h00);
    chk("mul_x", x_reg, 8'h10);

    // traps: div by zero, reserved bits, illegal opcode
    run_insn(16'h0033, 0);
    run_insn(16'h4000, 0);
    run_insn(16'h1100, 0);
    run_insn(16'h9000, 0);
    chk("trap_a", a_reg, 8'h33);

    // backpressure for 5 cycles with a competing instruction offered
    run_insn(16'h1001, 5);

    // src=X, dst=X reads pre-writeback X
    run_insn(16'h1C00, 2);

    // reset during EXEC of add A,#1 with A=0x7F
    run_insn(16'h007F, 0);
    @(negedge clk);
    in_valid = 1'b1; in_insn = 16'h1001;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ra = 8'd0; rx = 8'd0; rret = 16'd0;
    chk("mid_rst_a", a_reg, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_retired", retired, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("mid_rst_quiet", {out_valid, a_reg}, 0);
    end

    // randomized mix
    for (int n = 0; n < 300; n++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      ins[15:12] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) != 0) ins[9:8] = 2'b00;
      if ($urandom_range(0, 5) == 0) ins[7:0] = 8'h00;
      run_insn(ins, $urandom_range(0, 2));
    end

    // retire counter saturation
    @(negedge clk);
    force dut.retired = 16'hFFFE;
    #1 release dut.retired;
    rret = 16'hFFFE;
    run_insn(16'h0001, 0);
    run_insn(16'h1001, 0);
    run_insn(16'h0402, 0);
    chk("sat_retired", retired, 16'hFFFF);
    run_insn(16'h9000, 0);
    chk("sat_hold", retired, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
